// File: rtl/mac_learning_table.sv
// Fully associative learning MAC forwarding table: one request looks up the destination MAC and learns the source.
// Optional aging is enabled by defining MAC_TABLE_AGING_EN.
module mac_learning_table #(
  parameter int unsigned NUMBER_OF_PORTS = 4,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned AGE_TICK_CYCLES = 1000000,
  parameter int unsigned AGE_LIMIT       = 300,
  localparam int unsigned PW = $clog2(NUMBER_OF_PORTS),
  localparam int unsigned IW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       lookup_valid,
  output logic                       lookup_ready,
  input  logic [47:0]                lookup_destination_mac,
  input  logic [47:0]                lookup_source_mac,
  input  logic [PW-1:0]              lookup_source_port,
  input  logic                       flush,
  output logic                       result_valid,
  output logic                       result_hit,
  output logic [NUMBER_OF_PORTS-1:0] result_port_mask,
  output logic [CW-1:0]              table_entry_count
);

  if (NUMBER_OF_PORTS < 2 || DEPTH < 2 || AGE_LIMIT < 1 || AGE_TICK_CYCLES < 1) begin : g_param_check
    $error("mac_learning_table: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, MATCH, UPDATE, FLUSH} state_t;
  state_t state, state_next;

  logic [DEPTH-1:0] valid;
  logic [47:0]      mac_tab  [DEPTH];
  logic [PW-1:0]    port_tab [DEPTH];
  logic [IW-1:0]    victim;
  logic             flush_pending;

  logic [47:0]      dst_q, src_q;
  logic [PW-1:0]    src_port_q;

  logic             dst_hit, src_hit, free_any;
  logic [PW-1:0]    dst_port;
  logic [IW-1:0]    src_idx, free_idx;
  logic             port_ok, learn_en, hit_next;
  logic [NUMBER_OF_PORTS-1:0] all_but_src, mask_next;

  assign lookup_ready = (state == IDLE) && !flush && !flush_pending && !reset;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (flush) state_next = FLUSH;
              else if (lookup_valid && lookup_ready) state_next = MATCH;
      MATCH:  state_next = UPDATE;
      UPDATE: state_next = (flush_pending || flush) ? FLUSH : IDLE;
      FLUSH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dst_q      <= '0;
      src_q      <= '0;
      src_port_q <= '0;
    end else if (lookup_valid && lookup_ready) begin
      dst_q      <= lookup_destination_mac;
      src_q      <= lookup_source_mac;
      src_port_q <= lookup_source_port;
    end
  end

  // Destination compare is consumed in MATCH, source compare in UPDATE; the learn
  // commits at the end of UPDATE, so the lookup always sees the pre-learn table.
  always_comb begin
    dst_hit  = 1'b0;
    dst_port = '0;
    src_hit  = 1'b0;
    src_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && mac_tab[i] == dst_q) begin
        dst_hit  = 1'b1;
        dst_port = port_tab[i];
      end
      if (valid[i] && mac_tab[i] == src_q) begin
        src_hit = 1'b1;
        src_idx = IW'(i);
      end
      if (!valid[i] && !free_any) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    port_ok     = (32'(src_port_q) < NUMBER_OF_PORTS);
    learn_en    = port_ok && !src_q[40];
    all_but_src = '1;
    if (port_ok) all_but_src[src_port_q] = 1'b0;
    hit_next    = dst_hit && !dst_q[40];
    mask_next   = '0;
    if (!port_ok)                  mask_next = '1;
    else if (!hit_next)            mask_next = all_but_src;
    else if (dst_port != src_port_q) mask_next[dst_port] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_valid     <= 1'b0;
      result_hit       <= 1'b0;
      result_port_mask <= '0;
    end else begin
      result_valid <= (state == MATCH);
      if (state == MATCH) begin
        result_hit       <= hit_next;
        result_port_mask <= mask_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                      flush_pending <= 1'b0;
    else if (state == FLUSH)        flush_pending <= 1'b0;
    else if (flush && state != IDLE) flush_pending <= 1'b1;
  end

`ifdef MAC_TABLE_AGING_EN
  localparam int unsigned PSW = (AGE_TICK_CYCLES > 1) ? $clog2(AGE_TICK_CYCLES) : 1;
  localparam int unsigned AW  = $clog2(AGE_LIMIT + 1);
  logic [PSW-1:0] prescale;
  logic           age_tick;
  logic [AW-1:0]  age [DEPTH];

  assign age_tick = (prescale == PSW'(AGE_TICK_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || age_tick) prescale <= '0;
    else                   prescale <= prescale + 1'b1;
  end
`endif

  // Statement order encodes priority: expiry < learn/refresh < flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid  <= '0;
      victim <= '0;
`ifdef MAC_TABLE_AGING_EN
      for (int unsigned i = 0; i < DEPTH; i++) age[i] <= '0;
`endif
    end else begin
`ifdef MAC_TABLE_AGING_EN
      if (age_tick) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (valid[i]) begin
            if (age[i] >= AW'(AGE_LIMIT - 1)) begin
              valid[i] <= 1'b0;
              age[i]   <= '0;
            end else begin
              age[i] <= age[i] + 1'b1;
            end
          end
        end
      end
`endif
      if (state == UPDATE && learn_en) begin
        if (src_hit) begin
          port_tab[src_idx] <= src_port_q;
          valid[src_idx]    <= 1'b1;
`ifdef MAC_TABLE_AGING_EN
          age[src_idx]      <= '0;
`endif
        end else if (free_any) begin
          mac_tab[free_idx]  <= src_q;
          port_tab[free_idx] <= src_port_q;
          valid[free_idx]    <= 1'b1;
`ifdef MAC_TABLE_AGING_EN
          age[free_idx]      <= '0;
`endif
        end else begin
          mac_tab[victim]  <= src_q;
          port_tab[victim] <= src_port_q;
          valid[victim]    <= 1'b1;
`ifdef MAC_TABLE_AGING_EN
          age[victim]      <= '0;
`endif
          victim <= (victim == IW'(DEPTH - 1)) ? '0 : victim + 1'b1;
        end
      end
      if (state == FLUSH) begin
        valid <= '0;
`ifdef MAC_TABLE_AGING_EN
        for (int unsigned i = 0; i < DEPTH; i++) age[i] <= '0;
`endif
      end
    end
  end

  always_comb begin
    table_entry_count = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (valid[i]) table_entry_count = table_entry_count + CW'(1);
  end

endmodule
